// File: rtl/bitty_pkg.sv
// +----------------------------------------------------------------------+
// | bitty_pkg: shared encodings for the bitty fetch/issue unit           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package bitty_pkg;

  localparam int INSTR_W = 16;

  // Halt opcode lives in the two low bits of the instruction word
  localparam int         HALT_LSB  = 0;
  localparam int         HALT_MSB  = 1;
  localparam logic [1:0] HALT_CODE = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_LOAD  = 3'd2;
  localparam state_t ST_RUN   = 3'd3;
  localparam state_t ST_HALT  = 3'd4;

  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return word[HALT_MSB:HALT_LSB] == HALT_CODE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bitty_fetch_watchdog.sv
// +----------------------------------------------------------------------+
// | bitty_fetch_watchdog: counts RUN cycles, flags TIMEOUT expiry        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module bitty_fetch_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  // Clearing whenever RUN is left makes every RUN entry start from zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (!active) begin
      r_count <= '0;
    end else if (!expired) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign expired = active && (r_count == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/bitty_fetch.sv
// +----------------------------------------------------------------------+
// | bitty_fetch: instruction fetch/issue unit driving the run/done       |
// | handshake. Optional watchdog: define BITTY_FETCH_WATCHDOG_EN.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module bitty_fetch
  import bitty_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  pc_init,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               run,
  input  logic               done,
  output logic               busy,
  output logic               halted,
  output logic [ADDR_W-1:0]  pc,
  output logic [15:0]        retired,
  output logic               err
);

  state_t               r_state;
  state_t               w_next;
  logic [ADDR_W-1:0]    r_pc;
  logic [INSTR_W-1:0]   r_instr_q;
  logic                 r_done_q;
  logic [15:0]          r_retired;

  logic w_start_ok;
  logic w_complete;
  logic w_load_halt;
  logic w_wd_expire;

  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_HALT));
  assign w_complete  = (r_state == ST_RUN) && done && !r_done_q;
  assign w_load_halt = is_halt(mem_rdata);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_FETCH;
      ST_FETCH: w_next = ST_LOAD;
      ST_LOAD:  w_next = w_load_halt ? ST_HALT : ST_RUN;
      ST_RUN: begin
        if (w_complete) begin
          w_next = ST_FETCH;
        end else if (w_wd_expire) begin
          w_next = ST_HALT;
        end
      end
      ST_HALT:  if (start) w_next = ST_FETCH;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = 1'b0;
    run       = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_rd_en = 1'b1;
        busy      = 1'b1;
      end
      ST_LOAD:  busy = 1'b1;
      ST_RUN: begin
        run  = 1'b1;
        busy = 1'b1;
      end
      ST_HALT:  halted = 1'b1;
      default:  ;
    endcase
  end

  // The halt word is never latched so the issued instruction only moves on LOAD->RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc      <= '0;
      r_instr_q <= '0;
      r_done_q  <= 1'b0;
      r_retired <= '0;
    end else begin
      r_done_q <= done;
      if (w_start_ok) begin
        r_pc      <= pc_init;
        r_retired <= '0;
      end
      if ((r_state == ST_LOAD) && !w_load_halt) begin
        r_instr_q <= mem_rdata;
      end
      if (w_complete) begin
        r_pc <= r_pc + ADDR_W'(1);
        if (r_retired != 16'hFFFF) begin
          r_retired <= r_retired + 16'd1;
        end
      end
    end
  end

`ifdef BITTY_FETCH_WATCHDOG_EN
  logic r_err;

  bitty_fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .active  (r_state == ST_RUN),
    .expired (w_wd_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_start_ok) begin
      r_err <= 1'b0;
    end else if (w_wd_expire && !w_complete) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_cfg;

  assign w_wd_expire  = 1'b0;
  assign err          = 1'b0;
  assign w_unused_cfg = (TIMEOUT > 0);
`endif

  assign mem_addr    = r_pc;
  assign pc          = r_pc;
  assign instruction = r_instr_q;
  assign retired     = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_bitty_fetch.sv
// +----------------------------------------------------------------------+
// | tb_bitty_fetch: directed self-checking bench for bitty_fetch         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bitty_fetch;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  pc_init;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] instruction;
  logic        run;
  logic        done;
  logic        busy;
  logic        halted;
  logic [7:0]  pc;
  logic [15:0] retired;
  logic        err;

  logic [15:0] mem [0:255];

  int checks;
  int errors;

  bitty_fetch #(
    .ADDR_W  (8),
    .TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pc_init     (pc_init),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .instruction (instruction),
    .run         (run),
    .done        (done),
    .busy        (busy),
    .halted      (halted),
    .pc          (pc),
    .retired     (retired),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic do_start(input logic [7:0] addr);
    @(negedge clk);
    pc_init = addr;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_run(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (run) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_run timeout got run=%b exp 1", run);
    end
  endtask

  task automatic wait_halt(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_halt timeout got halted=%b exp 1", halted);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    done  = 1'b0;
    pc_init = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({run, busy, halted, mem_rd_en, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 00000", {run, busy, halted, mem_rd_en, err});
    end
    checks++;
    if ({pc, mem_addr, retired, instruction} !== 48'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", {pc, mem_addr, retired, instruction});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_basic();
    logic [15:0] exp_instr [2];
    bit ok;
    int len;
    exp_instr[0] = 16'h2408;
    exp_instr[1] = 16'h4A10;
    mem[0] = 16'h2408;
    mem[1] = 16'h4A10;
    mem[2] = 16'h0003;
    do_start(8'h00);
    checks++;
    if ({mem_rd_en, mem_addr} !== {1'b1, 8'h00}) begin
      errors++;
      $display("FAIL basic_fetch got %b/%h exp 1/00", mem_rd_en, mem_addr);
    end
    for (int k = 0; k < 2; k++) begin
      wait_run(10, ok);
      checks++;
      if (instruction !== exp_instr[k]) begin
        errors++;
        $display("FAIL basic_instr%0d got %h exp %h", k, instruction, exp_instr[k]);
      end
      len = 1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (run) len++;
      end
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      checks++;
      if (len !== 4 || run !== 1'b0) begin
        errors++;
        $display("FAIL basic_run_len%0d got %0d/%b exp 4/0", k, len, run);
      end
    end
    wait_halt(10, ok);
    checks++;
    if ({halted, busy, pc, retired} !== {1'b1, 1'b0, 8'h02, 16'd2}) begin
      errors++;
      $display("FAIL basic_halt got h=%b b=%b pc=%h ret=%0d exp 1 0 02 2", halted, busy, pc, retired);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    mem[8'hFF] = 16'h1234;
    mem[8'h00] = 16'h0003;
    do_start(8'hFF);
    checks++;
    if (mem_addr !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_fetch_ff got %h exp ff", mem_addr);
    end
    wait_run(10, ok);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    checks++;
    if ({mem_rd_en, mem_addr} !== {1'b1, 8'h00}) begin
      errors++;
      $display("FAIL wrap_fetch_00 got %b/%h exp 1/00", mem_rd_en, mem_addr);
    end
    wait_halt(10, ok);
    checks++;
    if ({pc, retired} !== {8'h00, 16'd1}) begin
      errors++;
      $display("FAIL wrap_halt got pc=%h ret=%0d exp 00 1", pc, retired);
    end
  endtask

  task automatic test_sticky_done();
    bit ok;
    mem[8'h10] = 16'h1111;
    mem[8'h11] = 16'h0003;
    done = 1'b1;
    do_start(8'h10);
    wait_run(10, ok);
    repeat (5) @(negedge clk);
    checks++;
    if ({run, retired} !== {1'b1, 16'd0}) begin
      errors++;
      $display("FAIL sticky_hold got run=%b ret=%0d exp 1 0", run, retired);
    end
    done = 1'b0;
    @(negedge clk);
    checks++;
    if (run !== 1'b1) begin
      errors++;
      $display("FAIL sticky_drop got run=%b exp 1", run);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    checks++;
    if ({run, retired} !== {1'b0, 16'd1}) begin
      errors++;
      $display("FAIL sticky_edge got run=%b ret=%0d exp 0 1", run, retired);
    end
    wait_halt(10, ok);
    checks++;
    if ({pc, retired} !== {8'h11, 16'd1}) begin
      errors++;
      $display("FAIL sticky_halt got pc=%h ret=%0d exp 11 1", pc, retired);
    end
  endtask

  task automatic test_restart();
    bit ok;
    mem[8'h04] = 16'h0003;
    do_start(8'h04);
    checks++;
    if ({retired, mem_rd_en, mem_addr} !== {16'd0, 1'b1, 8'h04}) begin
      errors++;
      $display("FAIL restart_fetch got ret=%0d rd=%b addr=%h exp 0 1 04", retired, mem_rd_en, mem_addr);
    end
    wait_halt(10, ok);
    checks++;
    if (pc !== 8'h04) begin
      errors++;
      $display("FAIL restart_halt got pc=%h exp 04", pc);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    mem[8'h08] = 16'h5550;
    mem[8'h09] = 16'h6660;
    do_start(8'h08);
    wait_run(10, ok);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    wait_run(10, ok);
    checks++;
    if ({instruction, retired, pc} !== {16'h6660, 16'd1, 8'h09}) begin
      errors++;
      $display("FAIL rst_pre got %h/%0d/%h exp 6660/1/09", instruction, retired, pc);
    end
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({run, busy, halted, mem_rd_en} !== 4'b0) begin
      errors++;
      $display("FAIL rst_mid_ctrl got %b exp 0000", {run, busy, halted, mem_rd_en});
    end
    checks++;
    if ({pc, retired, instruction} !== 40'h0) begin
      errors++;
      $display("FAIL rst_mid_data got %h exp 0", {pc, retired, instruction});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, halted} !== 2'b00) begin
      errors++;
      $display("FAIL rst_idle got %b exp 00", {busy, halted});
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    int cnt;
    mem[8'h20] = 16'h7770;
    done = 1'b0;
    do_start(8'h20);
    wait_run(10, ok);
    cnt = ok ? 1 : 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (!run) break;
      cnt++;
    end
`ifdef BITTY_FETCH_WATCHDOG_EN
    checks++;
    if (cnt !== 8) begin
      errors++;
      $display("FAIL wd_run_len got %0d exp 8", cnt);
    end
    checks++;
    if ({err, halted, run} !== 3'b110) begin
      errors++;
      $display("FAIL wd_expire got %b exp 110", {err, halted, run});
    end
`else
    checks++;
    if (cnt < 100) begin
      errors++;
      $display("FAIL wd_off_run_len got %0d exp >=100", cnt);
    end
    checks++;
    if ({err, run} !== 2'b01) begin
      errors++;
      $display("FAIL wd_off_state got %b exp 01", {err, run});
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int a = 0; a < 256; a++) mem[a] = 16'h0003;
    test_reset();
    test_basic();
    test_wrap();
    test_sticky_done();
    test_restart();
    test_reset_mid_run();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bitty_fetch.md
# bitty_fetch

Instruction fetch and issue unit for the bitty core. It reads 16-bit instruction words from a synchronous instruction memory, presents each word to the core with `run` held high, and waits for the core's `done` before fetching the next word. It sits between the instruction ROM/RAM and `bitty_core`, acting as the initiator of the run/done handshake. Program order, halting and retire counting all live in this block.

## Interface
- `ADDR_W`, default 8: instruction memory address width; the PC is this wide.
- `TIMEOUT`, default 64: watchdog limit in cycles. Used only when `BITTY_FETCH_WATCHDOG_EN` is defined.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled in IDLE; begins execution at `pc_init`.
- `pc_init` in ADDR_W: start address, captured when `start` is accepted.
- `mem_rd_en` out 1: memory read strobe.
- `mem_addr` out ADDR_W: memory address; equals the current PC.
- `mem_rdata` in 16: read data, valid the cycle after `mem_rd_en`.
- `instruction` out 16: word issued to the core.
- `run` out 1: issue strobe, held until completion.
- `done` in 1: core completion.
- `busy` out 1: high in every state except IDLE and HALT.
- `halted` out 1: high in HALT.
- `pc` out ADDR_W: current PC.
- `retired` out 16: count of completed instructions.
- `err` out 1: watchdog expiry. Tied to 0 when the watchdog is compiled out.

## Operation
- **States:** IDLE, FETCH, LOAD, RUN, HALT.
- **IDLE:**
  - `start`=1 → capture `pc` ← `pc_init`.
  - Clear `retired` and `err`.
  - Next state: FETCH.
- **FETCH:**
  - `mem_rd_en`=1, `mem_addr`=`pc`.
  - Next state: LOAD.
- **LOAD:** register `mem_rdata` into `instr_q`, then decode:
  - `mem_rdata[1:0]`==2'b11 is HALT_CODE: go to HALT. The word is not issued and `pc` is not advanced.
  - Otherwise: go to RUN.
- **RUN:**
  - `run`=1, `instruction`=`instr_q`, held stable.
  - Completion is a rising edge of `done`: `done`=1 while registered `done_q`=0.
  - On completion: `pc` ← `pc`+1 mod 2^ADDR_W, `retired` += 1 (saturates at 16'hFFFF), next state FETCH.
- **HALT:**
  - Stays here until `start`=1, which restarts exactly as from IDLE.
- **Wrap:** `pc` of 2^ADDR_W−1 advances to 0 with no flag.
- **`done` outside RUN:** ignored. `done_q` still tracks `done` every cycle.
- **`done` already high on entering RUN:** no edge, so the unit keeps waiting. The core must drop `done` after `run` falls.
- **`start` outside IDLE/HALT:** ignored.

## Timing
- Reset values: all outputs 0. State IDLE, `instr_q`=0, `done_q`=0. Reset takes effect immediately and asynchronously, including mid-RUN; `run` drops without waiting for `done`.
- Per-instruction cycle sequence:
  - Cycle 0: FETCH.
  - Cycle 1: LOAD, `mem_rdata` sampled.
  - Cycle 2 onward: RUN, `run`=1.
  - If the edge is seen at the clock ending cycle k, `run`=0 in cycle k+1, which is FETCH of the next word.
- Minimum issue overhead is 2 cycles per instruction plus core latency.
- `run` never pulses for less than one cycle and never re-asserts without an intervening FETCH and LOAD.
- `instruction` changes only on LOAD→RUN.

## Configuration
- `BITTY_FETCH_WATCHDOG_EN` defined:
  - A counter clears on entry to RUN and increments each RUN cycle.
  - Reaching `TIMEOUT` without completion sets `err`=1 (sticky until the next accepted `start`), drops `run` and goes to HALT.
- Not defined:
  - No counter is built, `err` is constant 0, and RUN waits indefinitely.

## Structure
- Shared package `bitty_pkg`:
  - State encoding (3-bit).
  - HALT_CODE = 2'b11 and the halt field position [1:0].
  - Instruction width 16.
- One sub-module: `bitty_fetch_watchdog`, holding the counter and compare. It is instantiated only under the macro.
- Edge detect and PC logic stay inline.

## Test plan
- **Basic program:** memory 0:16'h2408, 1:16'h4A10, 2:16'h0003, `pc_init`=0, core model asserts `done` 3 cycles after `run`.
  - Expect two `run` windows with `instruction` 16'h2408 then 16'h4A10.
  - Expect then `halted`=1, `pc`=2, `retired`=2.
- **Wrap:** ADDR_W=8, `pc_init`=8'hFF, word at 8'hFF non-halt, word at 0 = 16'h0003.
  - Expect `pc` to go FF→00, then halt with `retired`=1.
- **Sticky `done`:** `done` held high across RUN entry.
  - Expect no completion.
  - Drop `done`, then raise it: exactly one retire.
- **Reset mid-RUN:** assert `reset` low in cycle 3 of RUN.
  - Expect `run`, `busy`, `pc`, `retired` = 0 in the same cycle and state IDLE.
- **Watchdog:** macro on, `TIMEOUT`=8, `done` never asserted.
  - Expect `run` high for exactly 8 cycles, then `err`=1 and `halted`=1.
  - With the macro off: `run` stays high for 100 or more cycles and `err`=0.
- **Restart from HALT:** `start`=1 with `pc_init`=4.
  - Expect `retired` cleared and `mem_addr`=4 in the next FETCH.
